route_request_controller: RTL
=============================

Name: route_request_controller

Overview:
- Per-input-port requester that sits between an input flit buffer and one input of the crossbar switch.
- Decodes the head flit of each packet with XY routing on an N x N mesh.
- Issues a route reservation on the switch's request interface and waits for the grant.
- Streams the packet's flits into the switch, then relieves the route after the tail flit.
- It is the initiator side of the switch's reserve/status/relieve protocol.

Parameters:
N, 4, mesh dimension; coordinate width CW = $clog2(N)
DATA_WIDTH, 32, flit width
REQUEST_WIDTH, 3, width of output-port index sent to switch
X_COORD, 0, this router's X coordinate
Y_COORD, 0, this router's Y coordinate
COUNT_WIDTH, 16, width of packet/drop counters

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
data_in  input  DATA_WIDTH  flit from input buffer
valid_in  input  1  flit valid
ready_in  output  1  flit accepted when valid_in & ready_in
routeReserveRequestValid  output  1  reservation request valid
routeReserveRequest  output  REQUEST_WIDTH  requested output port index
routeReserveStatus  input  1  grant from switch, level
routeRelieve  output  1  one-cycle route release pulse
data_out  output  DATA_WIDTH  flit to switch input
valid_out  output  1  flit valid to switch
ready_out  input  1  switch ready
packetCount  output  COUNT_WIDTH  packets fully forwarded
dropCount  output  COUNT_WIDTH  stray non-head flits dropped

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE. All outputs are 0, including routeReserveRequest, routeRelieve, ready_in, valid_out, data_out and both counters.
- Flit type is data_in[DATA_WIDTH-1:DATA_WIDTH-2]:
  - 01 head, 00 body, 10 tail, 11 single (head+tail).
- Head destination fields:
  - destX = data_in[DATA_WIDTH-3 -: CW]
  - destY = the next CW bits below destX.
- Port encoding: 0 local, 1 north, 2 east, 3 south, 4 west.
- XY routing:
  - destX>X_COORD -> 2; destX<X_COORD -> 4.
  - Else destY>Y_COORD -> 1; destY<Y_COORD -> 3.
  - Else 0.
- IDLE:
  - ready_in=0 when valid_in holds a head/single flit. The head is NOT consumed.
  - On such a flit, register the computed port into routeReserveRequest and go to REQUEST next cycle.
  - If valid_in holds a body/tail flit: ready_in=1 (drop the flit), dropCount+1 (saturating at all-ones), stay IDLE.
- REQUEST:
  - routeReserveRequestValid=1; routeReserveRequest is held stable.
  - ready_in=0, valid_out=0.
  - When routeReserveStatus=1 is sampled, go to FORWARD. routeReserveRequestValid is 0 from the next cycle.
  - No timeout; the block waits indefinitely.
- FORWARD (zero-latency combinational pass-through):
  - data_out=data_in, valid_out=valid_in, ready_in=ready_out.
  - The first flit transferred is the held head.
  - When a tail or single flit completes the handshake (valid_in & ready_out), go to RELIEVE.
  - Flits after the tail in the same cycle are not possible; the next flit waits.
- RELIEVE:
  - routeRelieve=1 for exactly one cycle; ready_in=0, valid_out=0.
  - packetCount+1 (wraps modulo 2^COUNT_WIDTH).
  - Next state is IDLE. A new head may be decoded in the following cycle (IDLE), never in RELIEVE.
- valid_out is 0 outside FORWARD. data_out is don't-care-stable 0 outside FORWARD.
- A single flit is head and tail: REQUEST -> FORWARD (1 transfer) -> RELIEVE.
- Reset mid-packet (any state): immediately IDLE, no relieve pulse, counters cleared. The switch shares the reset.
- routeReserveStatus deasserting during FORWARD is ignored; forwarding continues until the tail.
- The registered route is loaded only in IDLE.

Test Plan:
- X_COORD=1, Y_COORD=1, N=4; head to (3,1), 2 body + tail, ready_out=1, grant 3 cycles after request:
  - routeReserveRequest=2 held for 3 cycles.
  - 4 flits forwarded in order, then a one-cycle routeRelieve.
  - packetCount=1.
- Heads to (0,1), (1,3), (1,0), (1,1) from X_COORD=1, Y_COORD=1 -> requested ports 4, 1, 3, 0 respectively, one packet each.
- Single flit 0b11 header, grant immediate:
  - Exactly 1 transfer.
  - routeRelieve pulses the cycle after the transfer.
  - packetCount increments by 1.
- Backpressure: ready_out toggles 1,0,0,1 during a 3-flit packet:
  - ready_in mirrors ready_out.
  - No flit duplicated or lost.
  - Relieve only after the tail handshake.
- Two body flits then a tail arrive while IDLE -> all 3 consumed and dropped; dropCount=3; no request issued.
- rst asserted asynchronously during FORWARD mid-packet:
  - All outputs 0 immediately, state IDLE, counters 0.
  - The next head triggers a fresh REQUEST.

Source files
------------

// File: rtl/route_request_controller.sv
// Per-input-port route requester for the mesh crossbar.
// Decodes XY route from head flit, reserves, streams, relieves.
module route_request_controller #(
    parameter int N             = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int REQUEST_WIDTH = 3,
    parameter int X_COORD       = 0,
    parameter int Y_COORD       = 0,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic                     routeReserveRequestValid,
    output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic                     routeReserveStatus,
    output logic                     routeRelieve,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic [COUNT_WIDTH-1:0]   packetCount,
    output logic [COUNT_WIDTH-1:0]   dropCount
);

    localparam int CW = $clog2(N);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQUEST = 2'd1;
    localparam logic [1:0] FORWARD = 2'd2;
    localparam logic [1:0] RELIEVE = 2'd3;

    localparam logic [CW-1:0] X_HERE = CW'(X_COORD);
    localparam logic [CW-1:0] Y_HERE = CW'(Y_COORD);

    logic [1:0]               state;
    logic [1:0]               state_next;
    logic [1:0]               flit_type;
    logic                     is_head;
    logic                     is_tail;
    logic [CW-1:0]            dest_x;
    logic [CW-1:0]            dest_y;
    logic [REQUEST_WIDTH-1:0] route_port;

    // Flit type: bit 0 marks a head (01/11), bit 1 marks a tail (10/11).
    assign flit_type = data_in[DATA_WIDTH-1 -: 2];
    assign is_head   = flit_type[0];
    assign is_tail   = flit_type[1];
    assign dest_x    = data_in[DATA_WIDTH-3 -: CW];
    assign dest_y    = data_in[DATA_WIDTH-3-CW -: CW];

    // XY routing: resolve X first, then Y, else eject locally.
    always_comb begin
        route_port = REQUEST_WIDTH'(0);
        if (dest_x > X_HERE)
            route_port = REQUEST_WIDTH'(2);
        else if (dest_x < X_HERE)
            route_port = REQUEST_WIDTH'(4);
        else if (dest_y > Y_HERE)
            route_port = REQUEST_WIDTH'(1);
        else if (dest_y < Y_HERE)
            route_port = REQUEST_WIDTH'(3);
    end

    assign routeReserveRequestValid = (state == REQUEST);
    assign routeRelieve             = (state == RELIEVE);

    // Next state and combinational flit path.
    always_comb begin
        state_next = state;
        ready_in   = 1'b0;
        valid_out  = 1'b0;
        data_out   = '0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (is_head)
                        state_next = REQUEST;
                    else
                        ready_in = !rst;
                end
            end
            REQUEST: begin
                if (routeReserveStatus)
                    state_next = FORWARD;
            end
            FORWARD: begin
                data_out  = data_in;
                valid_out = valid_in;
                ready_in  = ready_out;
                if (valid_in && ready_out && is_tail)
                    state_next = RELIEVE;
            end
            RELIEVE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Route is latched only while decoding a head in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            routeReserveRequest <= '0;
        else if (state == IDLE && valid_in && is_head)
            routeReserveRequest <= route_port;
    end

    // Forwarded packets wrap; dropped strays saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            packetCount <= '0;
            dropCount   <= '0;
        end else begin
            if (state == RELIEVE)
                packetCount <= packetCount + 1'b1;
            if (state == IDLE && valid_in && !is_head && dropCount != '1)
                dropCount <= dropCount + 1'b1;
        end
    end

endmodule
